// File: rtl/rgb_pwm_driver.sv
// Turns red/green/blue enables into PWM drive for the board RGB LED, with colour and duty applied only at period boundaries.
// Latency: LED pins are registered one clk behind the internal PWM counter; period_done is registered on the boundary edge.
// Backpressure: none; the block runs free, and inputs are sampled on every edge (colour only at period boundaries).
module rgb_pwm_driver #(
    parameter int CNT_W        = 8,
    parameter int PRESCALE     = 4,
    parameter int DUTY_DEFAULT = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red_in,
    input  logic             green_in,
    input  logic             blue_in,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_load,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_DEFAULT);

    logic             tick;
    logic             boundary;
    logic             pwm_on;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_shadow;
    logic [CNT_W-1:0] duty_active;
    logic [2:0]       col_latched;

    // PRESCALE=1 needs no divider register at all: every clk is a tick.
    generate
        if (PRESCALE > 1) begin : g_presc
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] presc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    presc <= '0;
                end else if (tick) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            assign tick = (presc == PW'(PRESCALE - 1));
        end else begin : g_nopresc
            assign tick = 1'b1;
        end
    endgenerate

    assign boundary = tick && (pwm_cnt == CNT_MAX);
    assign pwm_on   = (pwm_cnt < duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end
    end

    // A load coinciding with the boundary still hands the old shadow to duty_active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= DUTY_RST;
            duty_active <= DUTY_RST;
            col_latched <= 3'b000;
            period_done <= 1'b0;
        end else begin
            period_done <= boundary;
            if (duty_load) begin
                duty_shadow <= duty_in;
            end
            if (boundary) begin
                duty_active <= duty_shadow;
                col_latched <= {red_in, green_in, blue_in};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= col_latched[2] && pwm_on;
            led_g <= col_latched[1] && pwm_on;
            led_b <= col_latched[0] && pwm_on;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: PRESCALE=4 and PRESCALE=1 instances share stimulus,
// each checked every cycle against a period-arithmetic model plus literal period counts.
module tb_rgb_pwm_driver;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       red_in, green_in, blue_in;
    logic [7:0] duty_in;
    logic       duty_load;
    logic       led_r4, led_g4, led_b4, pd4;
    logic       led_r1, led_g1, led_b1, pd1;

    int n_vec = 0;
    int n_err = 0;

    rgb_pwm_driver #(.CNT_W(8), .PRESCALE(4), .DUTY_DEFAULT(128)) u4 (
        .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .duty_in(duty_in), .duty_load(duty_load),
        .led_r(led_r4), .led_g(led_g4), .led_b(led_b4), .period_done(pd4));

    rgb_pwm_driver #(.CNT_W(8), .PRESCALE(1), .DUTY_DEFAULT(128)) u1 (
        .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .duty_in(duty_in), .duty_load(duty_load),
        .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .period_done(pd1));

    always #5 clk = ~clk;

    function automatic int pre(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: edge k after reset sees pwm position floor((k-1)/P) mod N; every
    // k that is a multiple of P*N is a boundary that swaps in shadow duty and colour.
    int         m_k[2];
    int         m_duty[2];
    int         m_shadow[2];
    logic [2:0] m_col[2];
    logic [3:0] m_exp[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_k[i] = 0; m_duty[i] = 128; m_shadow[i] = 128;
                m_col[i] = 3'b000; m_exp[i] = 4'b0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int  k, pos;
                logic bnd;
                k   = m_k[i] + 1;
                pos = ((k - 1) / pre(i)) % N;
                bnd = (k % (pre(i) * N)) == 0;
                m_exp[i] = {m_col[i] & {3{pos < m_duty[i]}}, bnd};
                if (bnd) begin
                    m_duty[i] = m_shadow[i];
                    m_col[i]  = {red_in, green_in, blue_in};
                end
                if (duty_load) m_shadow[i] = int'(duty_in);
                m_k[i] = k;
            end
        end
    end

    always @(negedge clk) begin
        check("u4_outputs", {28'd0, led_r4, led_g4, led_b4, pd4}, {28'd0, m_exp[0]});
        check("u1_outputs", {28'd0, led_r1, led_g1, led_b1, pd1}, {28'd0, m_exp[1]});
    end

    task automatic wait_pd(input int sel);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((sel == 0) ? pd4 : pd1) break;
        end
        if (i == 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL pd_timeout: no period_done on dut %0d within 3000 clks", sel);
        end
    endtask

    task automatic set_duty(input logic [7:0] d, input int sel);
        @(negedge clk);
        duty_in   = d;
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        wait_pd(sel);
    endtask

    // Measures np whole periods starting right after an observed period_done,
    // optionally strobing a duty load or changing colour at a given sample.
    task automatic chk_period(input string tag, input int sel, input int np,
                              input int er, input int eg, input int eb,
                              input int load_at, input logic [7:0] lv,
                              input int col_at, input logic [2:0] cv);
        int hr, hg, hb, pdc, pdlast, len;
        hr = 0; hg = 0; hb = 0; pdc = 0; pdlast = -1;
        len = np * N * pre(sel);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            hr += int'((sel == 0) ? led_r4 : led_r1);
            hg += int'((sel == 0) ? led_g4 : led_g1);
            hb += int'((sel == 0) ? led_b4 : led_b1);
            if ((sel == 0) ? pd4 : pd1) begin
                pdc++;
                pdlast = i;
            end
            duty_load = (i == load_at);
            if (i == load_at) duty_in = lv;
            if (i == col_at) {red_in, green_in, blue_in} = cv;
        end
        duty_load = 1'b0;
        check({tag, "_r_high"}, hr, er);
        check({tag, "_g_high"}, hg, eg);
        check({tag, "_b_high"}, hb, eb);
        check({tag, "_pd_count"}, pdc, np);
        check({tag, "_pd_last"}, pdlast, len - 1);
    endtask

    initial begin
        rst_n = 1'b1;
        {red_in, green_in, blue_in} = 3'b111;
        duty_in = 8'd0;
        duty_load = 1'b0;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_u4", {28'd0, led_r4, led_g4, led_b4, pd4}, 32'd0);
        check("rst_u1", {28'd0, led_r1, led_g1, led_b1, pd1}, 32'd0);
        rst_n = 1'b1;
        {red_in, green_in, blue_in} = 3'b100;

        set_duty(8'd64, 0);
        chk_period("duty64_a", 0, 1, 256, 0, 0, -1, 8'd0, -1, 3'b000);
        chk_period("duty64_b", 0, 1, 256, 0, 0, -1, 8'd0, -1, 3'b000);

        set_duty(8'd0, 0);
        chk_period("duty0", 0, 3, 0, 0, 0, -1, 8'd0, -1, 3'b000);

        set_duty(8'd255, 0);
        chk_period("duty255", 0, 1, 1020, 0, 0, -1, 8'd0, -1, 3'b000);

        set_duty(8'd64, 0);
        chk_period("midload_cur", 0, 1, 256, 0, 0, 400, 8'd200, -1, 3'b000);
        chk_period("midload_next", 0, 1, 800, 0, 0, 1022, 8'd32, -1, 3'b000);
        chk_period("bndload_same", 0, 1, 800, 0, 0, -1, 8'd0, -1, 3'b000);
        chk_period("bndload_next", 0, 1, 128, 0, 0, -1, 8'd0, -1, 3'b000);

        chk_period("colour_cur", 0, 1, 128, 0, 0, -1, 8'd0, 40, 3'b001);
        chk_period("colour_next", 0, 1, 0, 0, 128, -1, 8'd0, -1, 3'b000);

        set_duty(8'd1, 1);
        chk_period("p1_duty1_a", 1, 1, 0, 0, 1, -1, 8'd0, -1, 3'b000);
        chk_period("p1_duty1_b", 1, 1, 0, 0, 1, -1, 8'd0, -1, 3'b000);

        set_duty(8'd255, 0);
        repeat (10) @(negedge clk);
        check("pre_async_b", {31'd0, led_b4}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_u4", {28'd0, led_r4, led_g4, led_b4, pd4}, 32'd0);
        check("async_rst_u1", {28'd0, led_r1, led_g1, led_b1, pd1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
